// File: rtl/program_sequencer.sv
// Fetch/execute control for a small instruction ROM: holds the PC, latches each
// instruction and decodes it into regfile, ALU-operand and output-port controls.
module program_sequencer #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16,
    parameter bit WRAP   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [3:0]        rf_ra,
    output logic [3:0]        rf_rb,
    output logic              alu_b_sel,
    output logic [DATA_W-1:0] imm,
    output logic              rf_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_OUT_WAIT,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_OUT  = 4'hF;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_q, pc_next;
    logic [31:0]       ir, ir_next;
    logic              illegal_q, illegal_next;
    logic [3:0]        opcode;
    logic              last_addr;
    logic              complete;
    logic              unused_ir_bits;

    assign opcode         = ir[31:28];
    assign rf_ra          = ir[27:24];
    assign rf_rb          = ir[23:20];
    assign imm            = DATA_W'(ir[15:0]);
    assign alu_b_sel      = (opcode == OP_ADDI);
    assign unused_ir_bits = ^ir[19:16];
    assign pc             = pc_q;
    assign rom_addr       = pc_q;
    assign illegal        = illegal_q;
    assign last_addr      = (pc_q == {ADDR_W{1'b1}});

    // Output handshake: a value transfers on a rising edge where out_valid && out_ready.
    // Once raised, out_valid stays high with rf_ra stable until that transfer happens.
    always_comb begin
        state_next   = state;
        pc_next      = pc_q;
        ir_next      = ir;
        illegal_next = illegal_q;
        rf_we        = 1'b0;
        out_valid    = 1'b0;
        halted       = 1'b0;
        complete     = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                ir_next    = rom_data;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                complete = 1'b1;
                case (opcode)
                    OP_NOP: ;
                    OP_ADDI, OP_ADD: rf_we = 1'b1;
                    OP_OUT: begin
                        out_valid = 1'b1;
                        complete  = out_ready;
                        if (!out_ready) state_next = S_OUT_WAIT;
                    end
                    default: illegal_next = 1'b1;
                endcase
            end
            S_OUT_WAIT: begin
                out_valid = 1'b1;
                complete  = out_ready;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
        // Retiring the last address either halts or wraps the PC back to 0.
        if (complete) begin
            if (last_addr && !WRAP) begin
                state_next = S_HALT;
            end else begin
                pc_next    = pc_q + 1'b1;
                state_next = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc_q      <= '0;
            ir        <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_next;
            pc_q      <= pc_next;
            ir        <= ir_next;
            illegal_q <= illegal_next;
        end
    end
endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: random and directed programs, a per-instruction event
// model feeding an expected queue, and a negedge monitor that pops and compares.
module tb_program_sequencer;
    localparam int W = 30;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // main instance (halts at the last address)
    logic        run;
    logic [2:0]  rom_addr;
    logic [31:0] rom_data;
    logic [3:0]  rf_ra, rf_rb;
    logic        alu_b_sel;
    logic [15:0] imm;
    logic        rf_we, out_valid, out_ready;
    logic [2:0]  pc;
    logic        halted, illegal;

    // wrapping instance, fed an all-NOP ROM
    logic        run_w;
    logic [2:0]  rom_addr_w;
    logic [31:0] rom_data_w;
    logic [3:0]  rf_ra_w, rf_rb_w;
    logic        alu_b_sel_w;
    logic [15:0] imm_w;
    logic        rf_we_w, out_valid_w, out_ready_w;
    logic [2:0]  pc_w;
    logic        halted_w, illegal_w;

    logic [31:0] rom [8];
    int          stall_of [8];

    assign rom_data    = rom[rom_addr];
    assign rom_data_w  = 32'h0;
    assign out_ready_w = 1'b1;

    program_sequencer #(.ADDR_W(3), .DATA_W(16), .WRAP(1'b0)) dut (
        .clk(clk), .rst(rst), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .alu_b_sel(alu_b_sel), .imm(imm), .rf_we(rf_we),
        .out_valid(out_valid), .out_ready(out_ready), .pc(pc), .halted(halted),
        .illegal(illegal)
    );

    program_sequencer #(.ADDR_W(3), .DATA_W(16), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .run(run_w), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
        .rf_ra(rf_ra_w), .rf_rb(rf_rb_w), .alu_b_sel(alu_b_sel_w), .imm(imm_w),
        .rf_we(rf_we_w), .out_valid(out_valid_w), .out_ready(out_ready_w), .pc(pc_w),
        .halted(halted_w), .illegal(illegal_w)
    );

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           exp_cycles;
    logic         exp_illegal;
    int           tests_run = 0;
    int           tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic score(input logic [W-1:0] act);
        if (exp_q.size() == 0) check("unexpected_event", act, 0);
        else check("event", act, exp_q.pop_front());
    endtask

    // Reference model: walk the program once in address order. Every ADDI/ADD yields
    // one write event, every OUT one transfer event; each instruction costs 2 cycles
    // plus the stall the responder applies to an OUT.
    task automatic build_model();
        logic [3:0] op;
        exp_q.delete();
        exp_cycles  = 0;
        exp_illegal = 1'b0;
        for (int a = 0; a < 8; a++) begin
            op = rom[a][31:28];
            exp_cycles += 2;
            if (op == 4'h1 || op == 4'h2) begin
                exp_q.push_back({2'd1, rom[a][27:24], rom[a][23:20], op == 4'h1,
                                 rom[a][15:0], 3'(a)});
            end else if (op == 4'hF) begin
                exp_q.push_back({2'd2, rom[a][27:24], rom[a][23:20], 1'b0,
                                 rom[a][15:0], 3'(a)});
                exp_cycles += stall_of[a];
            end else if (op != 4'h0) begin
                exp_illegal = 1'b1;
            end
        end
    endtask

    // monitor
    logic       prev_pending = 1'b0;
    logic [3:0] prev_ra = 4'h0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_pending) check("out_held", {out_valid, rf_ra}, {1'b1, prev_ra});
                if (rf_we || out_valid) check("we_and_valid_together", rf_we & out_valid, 0);
                if (rf_we) score({2'd1, rf_ra, rf_rb, alu_b_sel, imm, pc});
                if (out_valid && out_ready) score({2'd2, rf_ra, rf_rb, alu_b_sel, imm, pc});
            end
            prev_pending = out_valid && !out_ready && !rst;
            prev_ra      = rf_ra;
        end
    end

    // output-port responder: hold out_ready low for stall_of[addr] cycles, then accept
    logic in_out = 1'b0;
    int   stall_left = 0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && !rst) begin
                if (!in_out) begin
                    in_out     = 1'b1;
                    stall_left = stall_of[rom_addr];
                end
                if (stall_left == 0) begin
                    out_ready = 1'b1;
                end else begin
                    out_ready = 1'b0;
                    stall_left--;
                end
            end else begin
                in_out    = 1'b0;
                out_ready = 1'b0;
            end
        end
    end

    // driver tasks
    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs2, input logic [15:0] im);
        return {op, rd, rs2, 4'h0, im};
    endfunction

    task automatic load_base_program();
        rom[0] = mk(4'h1, 4'd1, 4'd0, 16'd5);
        rom[1] = mk(4'h1, 4'd2, 4'd0, 16'd10);
        for (int a = 2; a < 6; a++) rom[a] = 32'h0;
        rom[6] = mk(4'hF, 4'd1, 4'd0, 16'd0);
        rom[7] = mk(4'hF, 4'd2, 4'd0, 16'd0);
        for (int a = 0; a < 8; a++) stall_of[a] = 0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        run   = 1'b0;
        run_w = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("reset_state", {pc, halted, out_valid, rf_we, illegal, rf_ra},
              {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    endtask

    task automatic run_program(input bit drop_run);
        int n;
        do_reset();
        build_model();
        run = 1'b1;
        @(posedge clk);
        #1;
        if (drop_run) run = 1'b0;
        n = 0;
        while (!halted && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("cycles_to_halt", n, exp_cycles);
        check("illegal_flag", illegal, exp_illegal);
        check("halt_pc", pc, 3'd7);
        check("events_drained", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("halt_hold", {halted, pc, rf_we, out_valid}, {1'b1, 3'd7, 1'b0, 1'b0});
        run = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        run_w     = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rom[a]      = 32'h0;
            stall_of[a] = 0;
        end

        // base program, ready always high: 16 cycles
        load_base_program();
        run_program(1'b0);

        // first OUT stalled 5 cycles: 21 cycles
        load_base_program();
        stall_of[6] = 5;
        run_program(1'b1);

        // ADD r1,r2 at address 2
        load_base_program();
        rom[2] = mk(4'h2, 4'd1, 4'd2, 16'h0);
        run_program(1'b0);

        // illegal opcode at address 3
        load_base_program();
        rom[3] = mk(4'h5, 4'd0, 4'd0, 16'h0);
        run_program(1'b1);

        // wrap instance: PC 0..7,0,1.. and never halts
        do_reset();
        run_w = 1'b1;
        @(posedge clk);
        #1;
        run_w = 1'b0;
        for (int n = 0; n < 40; n++) begin
            check("wrap_pc", {halted_w, pc_w}, {1'b0, 3'((n / 2) % 8)});
            @(posedge clk);
            #1;
        end
        check("wrap_no_strobes", {rf_we_w, out_valid_w, illegal_w}, 3'b000);

        // reset while an OUT waits for ready
        for (int a = 0; a < 8; a++) begin
            rom[a]      = 32'h0;
            stall_of[a] = 0;
        end
        rom[0]      = mk(4'h5, 4'd0, 4'd0, 16'h0);
        rom[1]      = mk(4'hF, 4'd3, 4'd0, 16'h0);
        stall_of[1] = 20;
        do_reset();
        build_model();
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        begin
            int n;
            n = 0;
            while (!(out_valid && !out_ready && pc == 3'd1) && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("reached_out", {out_valid, pc}, {1'b1, 3'd1});
        end
        @(posedge clk);
        #1;
        check("in_out_wait", {out_valid, illegal, rf_ra}, {1'b1, 1'b1, 4'd3});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("reset_mid_out", {pc, out_valid, halted, illegal, rf_we},
              {3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            check("idle_after_reset", {pc, out_valid, rf_we, halted}, {3'd0, 1'b0, 1'b0, 1'b0});
        end

        // random programs
        for (int t = 0; t < 30; t++) begin
            for (int a = 0; a < 8; a++) begin
                logic [31:0] word;
                int          kind;
                word = $urandom;
                kind = $urandom_range(0, 4);
                case (kind)
                    0: word[31:28] = 4'h0;
                    1: word[31:28] = 4'h1;
                    2: word[31:28] = 4'h2;
                    3: word[31:28] = 4'hF;
                    default: word[31:28] = 4'($urandom_range(3, 14));
                endcase
                rom[a]      = word;
                stall_of[a] = $urandom_range(0, 4);
            end
            run_program(1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
